// File: rtl/ram_fifo_ctrl_if.sv
// Bus bundle between a push/pop client, the FIFO controller and the 32x4 dual-port RAM.
// Defining FIFO_ERR_FLAGS_EN adds the sticky ovf/unf error flags.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
);
    logic              push;
    logic [DATA_W-1:0] wr_data;
    logic              pop;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              ram_ena;
    logic              ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [DATA_W-1:0] ram_dia;
    logic              ram_enb;
    logic [ADDR_W-1:0] ram_addrb;
    logic [DATA_W-1:0] ram_dob;
`ifdef FIFO_ERR_FLAGS_EN
    logic              ovf;
    logic              unf;

    modport slave (
        input  push, wr_data, pop, ram_dob,
        output rd_data, rd_valid, full, empty, count,
        output ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb,
        output ovf, unf
    );

    modport master (
        output push, wr_data, pop, ram_dob,
        input  rd_data, rd_valid, full, empty, count,
        input  ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb,
        input  ovf, unf
    );
`else
    modport slave (
        input  push, wr_data, pop, ram_dob,
        output rd_data, rd_valid, full, empty, count,
        output ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb
    );

    modport master (
        output push, wr_data, pop, ram_dob,
        input  rd_data, rd_valid, full, empty, count,
        input  ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb
    );
`endif
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port RAM: port A writes, port B reads (1-cycle latency).
// Optional sticky overflow/underflow flags are enabled with FIFO_ERR_FLAGS_EN.
module ram_fifo_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_rdValid;
    logic              w_pushAcc;
    logic              w_popAcc;
    logic [ADDR_W:0]   w_countNext;
    logic [DATA_W-1:0] w_rdData;

    // Acceptance uses the registered flags, so write and read addresses can never collide.
    assign w_pushAcc = bus.push & ~r_full & ~rst;
    assign w_popAcc  = bus.pop & ~r_empty & ~rst;

    always_comb begin
        w_countNext = r_count;
        case ({w_pushAcc, w_popAcc})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_rdValid <= 1'b0;
        end else begin
            if (w_pushAcc) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popAcc) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count   <= w_countNext;
            r_full    <= (w_countNext == FULL_COUNT);
            r_empty   <= (w_countNext == '0);
            r_rdValid <= w_popAcc;
        end
    end

    assign w_rdData      = bus.ram_dob;
    assign bus.rd_data   = w_rdData;
    assign bus.rd_valid  = r_rdValid;
    assign bus.full      = r_full;
    assign bus.empty     = r_empty;
    assign bus.count     = r_count;
    assign bus.ram_ena   = w_pushAcc;
    assign bus.ram_wea   = w_pushAcc;
    assign bus.ram_addra = r_wrPtr;
    assign bus.ram_dia   = bus.wr_data;
    assign bus.ram_enb   = w_popAcc;
    assign bus.ram_addrb = r_rdPtr;

`ifdef FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_unf;

    // Flags record any rejected request and stay set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (bus.push & r_full);
            r_unf <= r_unf | (bus.pop & r_empty);
        end
    end

    assign bus.ovf = r_ovf;
    assign bus.unf = r_unf;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO reference model.
module tb_ram_fifo_ctrl;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } expT;

    logic clk = 1'b0;
    logic rst;

    int   compared   = 0;
    int   mismatched = 0;
    int   cycleNo    = 0;
    bit   monitorOn  = 1'b0;

    logic [DATA_W-1:0] modelQ[$];
    int                pushTotal;
    int                popTotal;
    bit                modelOvf;
    bit                modelUnf;
    expT               sbQ[$];
    expT               monE;
    logic [DATA_W-1:0] ramMem [DEPTH];

    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 32x4 dual-port RAM: port A writes, port B reads with a registered output.
    always @(posedge clk) begin
        if (bus.ram_ena && bus.ram_wea) begin
            ramMem[bus.ram_addra] <= bus.ram_dia;
        end
        if (bus.ram_enb) begin
            bus.ram_dob <= ramMem[bus.ram_addrb];
        end
    end

    always @(posedge clk) cycleNo <= cycleNo + 1;

    function automatic void compareVal(string name, logic [31:0] actual, logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleNo);
        end
    endfunction

    // Monitor: every rd_valid pulse must match the oldest expected read, on the expected cycle.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (bus.rd_valid) begin
                if (sbQ.size() == 0) begin
                    compareVal("rd_valid_unexpected", bus.rd_valid, 32'd0);
                end else begin
                    monE = sbQ.pop_front();
                    compareVal("rd_data", bus.rd_data, monE.data);
                    compareVal("rd_valid_cycle", cycleNo, monE.due);
                end
            end else if (sbQ.size() > 0 && sbQ[0].due <= cycleNo) begin
                monE = sbQ.pop_front();
                compareVal("rd_valid_missing", bus.rd_valid, 32'd1);
            end
        end
    end

    // Compares the DUT against the model for the current cycle, then advances the model across the edge.
    task automatic checkOutput(input bit p, input logic [DATA_W-1:0] d, input bit q, input bit r);
        bit pushAcc;
        bit popAcc;
        pushAcc = p && (modelQ.size() < DEPTH) && !r;
        popAcc  = q && (modelQ.size() > 0) && !r;

        compareVal("count", bus.count, modelQ.size());
        compareVal("empty", bus.empty, modelQ.size() == 0);
        compareVal("full", bus.full, modelQ.size() == DEPTH);
        compareVal("ram_ena", bus.ram_ena, pushAcc);
        compareVal("ram_wea", bus.ram_wea, pushAcc);
        compareVal("ram_enb", bus.ram_enb, popAcc);
        compareVal("ram_addra", bus.ram_addra, pushTotal % DEPTH);
        compareVal("ram_addrb", bus.ram_addrb, popTotal % DEPTH);
        if (pushAcc) begin
            compareVal("ram_dia", bus.ram_dia, d);
        end
`ifdef FIFO_ERR_FLAGS_EN
        compareVal("ovf", bus.ovf, modelOvf);
        compareVal("unf", bus.unf, modelUnf);
`endif

        if (r) begin
            modelQ.delete();
            pushTotal = 0;
            popTotal  = 0;
            modelOvf  = 1'b0;
            modelUnf  = 1'b0;
        end else begin
            if (p && modelQ.size() == DEPTH) modelOvf = 1'b1;
            if (q && modelQ.size() == 0)     modelUnf = 1'b1;
            if (popAcc) begin
                sbQ.push_back('{due: cycleNo + 1, data: modelQ.pop_front()});
                popTotal++;
            end
            if (pushAcc) begin
                modelQ.push_back(d);
                pushTotal++;
            end
        end
    endtask

    task automatic applyStimulus(input bit p, input logic [DATA_W-1:0] d, input bit q, input bit r);
        bus.push    = p;
        bus.wr_data = d;
        bus.pop     = q;
        rst         = r;
        #1;
        checkOutput(p, d, q, r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit p;
        bit q;
        int pushedItems;
        int guard;

        rst         = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.wr_data = '0;
        @(posedge clk);
        #1;
        modelQ.delete();
        pushTotal = 0;
        popTotal  = 0;
        modelOvf  = 1'b0;
        modelUnf  = 1'b0;
        monitorOn = 1'b1;

        $display("[TB] reset and basic traffic");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        $display("[TB] fill to full and overflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 4'(i % 16), 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        idle(1);

        $display("[TB] simultaneous push and pop at full, then drain");
        applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
        idle(1);
        while (modelQ.size() > 0) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        $display("[TB] simultaneous push and pop at empty, then underflow");
        applyStimulus(1'b1, 4'h9, 1'b1, 1'b0);
        idle(1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        $display("[TB] low-occupancy streaming across pointer wrap");
        pushedItems = 0;
        guard       = 0;
        while ((pushedItems < 70 || modelQ.size() > 0) && guard < 2000) begin
            p = (pushedItems < 70) && (modelQ.size() < 3) && ($urandom_range(0, 3) != 0);
            q = ($urandom_range(0, 2) != 0);
            if (p) pushedItems++;
            applyStimulus(p, 4'($urandom), q, 1'b0);
            guard++;
        end
        compareVal("stream_items_pushed", pushedItems, 32'd70);
        idle(2);

        $display("[TB] reset in the middle of traffic");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'(i + 1), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        idle(1);
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 99) < 55), 4'($urandom), ($urandom_range(0, 99) < 45), 1'b0);
        end
        idle(3);

        compareVal("scoreboard_drained", sbQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
